phase_timer: RTL and testbench



---
 rtl/traffic_pkg.sv | 39 +++
 rtl/phase_timer_prescaler.sv | 35 +++
 rtl/phase_timer.sv | 72 +++++++
 tb/tb_phase_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared intersection-controller definitions: phase codes, default dwell
// durations and the phase -> duration lookup used by the phase timer.
package traffic_pkg;

  localparam logic [2:0] N_GREEN  = 3'd0;
  localparam logic [2:0] N_YELLOW = 3'd1;
  localparam logic [2:0] RED_1    = 3'd2;
  localparam logic [2:0] E_LEFT   = 3'd3;
  localparam logic [2:0] E_GREEN  = 3'd4;
  localparam logic [2:0] E_YELLOW = 3'd5;
  localparam logic [2:0] RED_2    = 3'd6;
  localparam logic [2:0] N_LEFT   = 3'd7;

  localparam int DEF_T_GREEN  = 30;
  localparam int DEF_T_YELLOW = 4;
  localparam int DEF_T_RED    = 2;
  localparam int DEF_T_LEFT   = 8;

  typedef enum logic {RUN = 1'b0, EXPIRED = 1'b1} mode_t;

  // Duration in ticks, truncated to cw bits; zero (before or after
  // truncation) becomes 1 so a phase can never start already expired.
  function automatic logic [31:0] phase_dur(input logic [2:0] phase, input int cw,
                                            input int tg, input int ty,
                                            input int tr, input int tl);
    logic [31:0] raw;
    logic [31:0] mask;
    case (phase[1:0])
      2'd0:    raw = tg;
      2'd1:    raw = ty;
      2'd2:    raw = tr;
      default: raw = tl;
    endcase
    mask = (cw >= 32) ? '1 : ((32'd1 << cw) - 32'd1);
    raw  = raw & mask;
    return (raw == 32'd0) ? 32'd1 : raw;
  endfunction

endpackage

// File: rtl/phase_timer_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled; clear restarts the
// count. wrap is the combinational "this edge ends a tick period" strobe.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic wrap,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;

  assign wrap = en && !clear && (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (wrap) begin
      pre  <= '0;
      tick <= 1'b1;
    end else begin
      pre  <= pre + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Per-phase dwell timer: reloads on every phase change, counts down in
// prescaled ticks and fires a single-cycle expire to advance the FSM.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CW       = 6,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_RED    = DEF_T_RED,
  parameter int T_LEFT   = DEF_T_LEFT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    phase,
  input  logic          hold,
  output logic          expire,
  output logic          tick,
  output logic [CW-1:0] remaining
);

  localparam logic [CW-1:0] DUR_RESET =
    CW'(phase_dur(N_GREEN, CW, T_GREEN, T_YELLOW, T_RED, T_LEFT));

  logic [2:0]    phase_q;
  mode_t         mode;
  logic          reload;
  logic          wrap;
  logic [CW-1:0] dur_next;

  assign reload   = (phase != phase_q);
  assign dur_next = CW'(phase_dur(phase, CW, T_GREEN, T_YELLOW, T_RED, T_LEFT));

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clear (reload),
    .en    (!hold),
    .wrap  (wrap),
    .tick  (tick)
  );

  // Reload outranks the final tick, so a coincident phase change never
  // produces a stray expire.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= N_GREEN;
      remaining <= DUR_RESET;
      mode      <= RUN;
      expire    <= 1'b0;
    end else if (reload) begin
      phase_q   <= phase;
      remaining <= dur_next;
      mode      <= RUN;
      expire    <= 1'b0;
    end else if (hold) begin
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (wrap && mode == RUN) begin
        if (remaining > CW'(1)) begin
          remaining <= remaining - 1'b1;
        end else begin
          remaining <= '0;
          expire    <= 1'b1;
          mode      <= EXPIRED;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: stimulus queues expected samples and
// expire cycles; a negedge monitor pops and compares them.
module tb_phase_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] phase;
  logic [2:0] phase_man = 3'd0;
  logic [2:0] fsm_q = 3'd0;
  logic       loop_en = 1'b0;
  logic       hold = 1'b0;
  logic       expire;
  logic       tick;
  logic [5:0] remaining;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic [5:0] rem;
    logic       tk;
    logic       ex;
    string      tag;
  } smp_t;

  smp_t smp_q[$];
  int   exp_q[$];

  // Dwell ticks per phase for the bench parameter set
  int dur_tab[8] = '{3, 2, 1, 2, 3, 2, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Minimal stand-in for the control FSM: advance one phase per expire
  always @(posedge clk) begin
    if (reset) fsm_q <= 3'd0;
    else if (expire) fsm_q <= fsm_q + 3'd1;
  end

  assign phase = loop_en ? fsm_q : phase_man;

  phase_timer #(
    .TICK_DIV (4),
    .CW       (6),
    .T_GREEN  (3),
    .T_YELLOW (2),
    .T_RED    (1),
    .T_LEFT   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .phase     (phase),
    .hold      (hold),
    .expire    (expire),
    .tick      (tick),
    .remaining (remaining)
  );

  always @(negedge clk) begin
    if (expire === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL expire_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL expire_cycle: pulse at cycle %0d, required at %0d", cyc, e);
        end
      end
    end
    while (smp_q.size() > 0 && smp_q[0].c <= cyc) begin
      smp_t s;
      s = smp_q.pop_front();
      checks++;
      if (s.c != cyc || remaining !== s.rem || tick !== s.tk || expire !== s.ex) begin
        errors++;
        $display("FAIL %s@%0d: rem=%0d tick=%b expire=%b, required rem=%0d tick=%b expire=%b",
                 s.tag, s.c, remaining, tick, expire, s.rem, s.tk, s.ex);
      end
    end
  end

  task automatic push_s(input int c, input int rem, input logic tk, input logic ex,
                        input string tag);
    smp_t s;
    s.c = c; s.rem = rem[5:0]; s.tk = tk; s.ex = ex; s.tag = tag;
    smp_q.push_back(s);
  endtask

  task automatic to_cyc(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  initial begin
    int r, l, m, x;
    @(negedge clk);

    // Reset release, phase 0 runs to expiry and stays expired
    reset = 1'b1; phase_man = 3'd0; hold = 1'b0;
    r = cyc + 1;
    push_s(r,      3, 0, 0, "t1_reset");
    push_s(r + 3,  3, 0, 0, "t1_pre3");
    push_s(r + 4,  2, 1, 0, "t1_tick1");
    push_s(r + 8,  1, 1, 0, "t1_tick2");
    push_s(r + 12, 0, 1, 1, "t1_expire");
    push_s(r + 16, 0, 1, 0, "t1_expired_stays");
    exp_q.push_back(r + 12);
    to_cyc(r); reset = 1'b0;
    to_cyc(r + 20);

    // Phase 0 -> 1 with remaining=2
    reset = 1'b1;
    r = cyc + 1;
    l = r + 6;
    push_s(r + 5, 2, 0, 0, "t2_before");
    push_s(l,     2, 0, 0, "t2_reload");
    push_s(l + 3, 2, 0, 0, "t2_pre_restart");
    push_s(l + 4, 1, 1, 0, "t2_tick1");
    push_s(l + 8, 0, 1, 1, "t2_expire");
    exp_q.push_back(l + 8);
    to_cyc(r); reset = 1'b0;
    to_cyc(r + 5); phase_man = 3'd1;
    to_cyc(l + 12);

    // Hold for 10 cycles in phase 3
    phase_man = 3'd3;
    l = cyc + 1;
    push_s(l,     2, 0, 0, "t3_reload");
    push_s(l + 2, 2, 0, 0, "t3_pre2");
    for (int k = 3; k <= 12; k++) push_s(l + k, 2, 0, 0, "t3_hold");
    push_s(l + 13, 2, 0, 0, "t3_resume");
    push_s(l + 14, 1, 1, 0, "t3_tick1");
    push_s(l + 18, 0, 1, 1, "t3_expire");
    exp_q.push_back(l + 18);
    to_cyc(l + 2);  hold = 1'b1;
    to_cyc(l + 12); hold = 1'b0;
    to_cyc(l + 22);

    // Phase change coincident with the final tick of phase 2
    phase_man = 3'd2;
    l = cyc + 1;
    push_s(l,      1, 0, 0, "t4_reload");
    push_s(l + 3,  1, 0, 0, "t4_last_pre");
    push_s(l + 4,  3, 0, 0, "t4_coincident");
    push_s(l + 8,  2, 1, 0, "t4_tick1");
    push_s(l + 16, 0, 1, 1, "t4_expire");
    exp_q.push_back(l + 16);
    to_cyc(l + 3); phase_man = 3'd4;
    to_cyc(l + 20);

    // Reset mid-count in phase 5
    phase_man = 3'd5;
    m = cyc + 1;
    push_s(m + 4,  1, 1, 0, "t6_tick1");
    push_s(m + 5,  3, 0, 0, "t6_reset");
    push_s(m + 8,  3, 0, 0, "t6_pre_restart");
    push_s(m + 9,  2, 1, 0, "t6_tick1_after");
    push_s(m + 17, 0, 1, 1, "t6_expire");
    exp_q.push_back(m + 17);
    to_cyc(m + 4); reset = 1'b1;
    to_cyc(m + 5); reset = 1'b0; phase_man = 3'd0;
    to_cyc(m + 20);

    // Closed loop: expire -> FSM edge -> timer reload, 4*dur+2 apart
    reset = 1'b1; loop_en = 1'b1;
    r = cyc + 1;
    x = r + 12;
    exp_q.push_back(x);
    push_s(x + 2, 2, 0, 0, "t5_reload_p1");
    for (int i = 1; i <= 8; i++) begin
      x = x + 2 + 4 * dur_tab[i % 8];
      exp_q.push_back(x);
    end
    to_cyc(r); reset = 1'b0;
    to_cyc(x + 3);
    loop_en = 1'b0;
    @(negedge clk);

    while (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL expire_missing: required at cycle %0d, no pulse", exp_q.pop_front());
    end
    while (smp_q.size() > 0) begin
      smp_t s;
      s = smp_q.pop_front();
      checks++; errors++;
      $display("FAIL %s_unchecked: sample for cycle %0d never compared", s.tag, s.c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
